rd_tag_tracker: RTL and testbench
=================================

# rd_tag_tracker

Read-request tag tracker between `afu_manager`'s read port and the CCI-P c0 channel in `app_afu`. Each upstream read request is given a free local tag, which is sent as the CCI mdata. The upstream mdata is parked in a tag-indexed table. When the read response arrives, the original mdata is restored and the tag is freed. This bounds outstanding reads to NUM_TAGS, lets responses return out of order, and flags responses whose tag is not outstanding.

## Interface
- NUM_TAGS, 32: maximum outstanding reads; power of two, 2..128
- ADDR_W, 48: byte-address width
- MDATA_W, 16: upstream and CCI mdata width; must be ≥ log2(NUM_TAGS)
- DATA_W, 512: cache-line width
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- up_rd_en  in  1  upstream read request; counted only when up_rd_available is high
- up_rd_available  out  1  a free tag exists and cci_almfull is low
- up_rd_addr  in  ADDR_W  byte address of the line
- up_rd_mdata  in  MDATA_W  upstream tag to be returned with the response
- cci_rd_en  out  1  read request to the FIU (feeds c0Tx valid)
- cci_rd_addr  out  ADDR_W  registered copy of up_rd_addr
- cci_rd_mdata  out  MDATA_W  allocated tag, zero-extended
- cci_almfull  in  1  c0TxAlmFull
- cci_resp_valid  in  1  read response present (cci_c0Rx_isReadRsp)
- cci_resp_mdata  in  MDATA_W  response tag
- cci_resp_data  in  DATA_W  response line
- up_resp_valid  out  1  response to upstream
- up_resp_mdata  out  MDATA_W  restored upstream mdata
- up_resp_data  out  DATA_W  response line
- outstanding  out  log2(NUM_TAGS)+1  number of tags in use
- idle  out  1  outstanding == 0
- err_spurious  out  1  sticky flag: a response arrived with an unallocated or out-of-range tag

## Operation
- State: a NUM_TAGS-bit busy bitmap and a NUM_TAGS×MDATA_W mdata table.
- Accept: when up_rd_en && up_rd_available:
  - pick the lowest-index free tag;
  - set its busy bit and write up_rd_mdata into the table;
  - register addr and tag onto the cci_rd_* outputs with cci_rd_en=1.
- Otherwise cci_rd_en=0 next cycle; cci_rd_addr and cci_rd_mdata hold their last value.
- Response with a busy tag:
  - up_resp_valid=1 next cycle, with the table mdata and the registered data;
  - the busy bit is cleared in the same edge.
- Response with a non-busy tag, or a tag ≥ NUM_TAGS: the response is dropped (up_resp_valid stays 0) and err_spurious is set. err_spurious clears only on rst.
- Accept and free in the same cycle: both take effect.
  - outstanding is unchanged.
  - The freed tag is not allocatable until the next cycle. up_rd_available is computed from the registered bitmap only.
- Accept and free of the same tag in the same cycle is impossible, because the allocated tag is never busy.
- Flow control: up_rd_available = (outstanding < NUM_TAGS) && !cci_almfull, combinational from registered state plus cci_almfull. At most one request is issued after almfull rises, which CCI-P tolerates.
- Reset mid-operation:
  - bitmap cleared, outstanding=0, all outputs go to their reset values;
  - responses arriving after reset for tags issued before reset are treated as spurious.

## Timing
- Reset values:
  - cci_rd_en=0, up_resp_valid=0, err_spurious=0, outstanding=0, idle=1;
  - cci_rd_addr, cci_rd_mdata, up_resp_mdata and up_resp_data =0;
  - up_rd_available = !cci_almfull.
- Request latency: 1 cycle from accept to cci_rd_en.
- Response latency: 1 cycle from cci_resp_valid to up_resp_valid.
- Throughput: one request and one response per cycle, sustained.
- outstanding updates on the edge after an accept or a free. idle is decoded from the registered outstanding.

## Configuration
- RD_TAG_TRACKER_STATS_EN defined:
  - adds outputs stat_req (32 b), stat_resp (32 b) and stat_peak (log2(NUM_TAGS)+1 b);
  - stat_req counts accepts, stat_resp counts valid responses, stat_peak is the running max of outstanding;
  - stat_req and stat_resp wrap at 2^32; all three clear on rst.
- Undefined: the three ports still exist but are tied to 0, and no counter logic is built.

## Test plan
- Single read: accept addr 0x1000 with mdata 0x00AB; return a response with tag 0 and data 0x55…5.
  - Required: cci_rd_en one cycle later, cci_rd_mdata=0; up_resp_valid with mdata 0x00AB one cycle after the response; idle=1 afterwards.
- Fill: NUM_TAGS=32, 32 back-to-back accepts.
  - Required: tags 0..31 issued in order; up_rd_available=0 from the cycle outstanding=32.
  - Then free tag 7: up_rd_available=1 next cycle, and the next accept gets tag 7.
- Out-of-order return: issue tags 0..3 with mdata 10..13, respond in order 3,1,0,2.
  - Required: up_resp_mdata 13,11,10,12.
- Simultaneous accept and free: outstanding=5, accept and free in the same cycle.
  - Required: outstanding stays 5; no lost or duplicated tag.
- Spurious response: response with tag 9 while tag 9 is free.
  - Required: no up_resp_valid, err_spurious=1 and held until rst.
- almfull and reset: raise cci_almfull with up_rd_en held high.
  - Required: up_rd_available=0 immediately, no cci_rd_en from the following cycle.
  - Then assert rst with 4 tags outstanding: outstanding=0 next cycle; a later response with tag 2 sets err_spurious.

Source files
------------

// File: rtl/rd_tag_tracker.sv
// Read-request tag tracker: allocates local CCI tags, parks upstream mdata, restores it on response.
// Optional statistics counters are built when RD_TAG_TRACKER_STATS_EN is defined.
module rd_tag_tracker #(
  parameter int NUM_TAGS = 32,
  parameter int ADDR_W   = 48,
  parameter int MDATA_W  = 16,
  parameter int DATA_W   = 512
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        up_rd_en,
  output logic                        up_rd_available,
  input  logic [ADDR_W-1:0]           up_rd_addr,
  input  logic [MDATA_W-1:0]          up_rd_mdata,
  output logic                        cci_rd_en,
  output logic [ADDR_W-1:0]           cci_rd_addr,
  output logic [MDATA_W-1:0]          cci_rd_mdata,
  input  logic                        cci_almfull,
  input  logic                        cci_resp_valid,
  input  logic [MDATA_W-1:0]          cci_resp_mdata,
  input  logic [DATA_W-1:0]           cci_resp_data,
  output logic                        up_resp_valid,
  output logic [MDATA_W-1:0]          up_resp_mdata,
  output logic [DATA_W-1:0]           up_resp_data,
  output logic [$clog2(NUM_TAGS):0]   outstanding,
  output logic                        idle,
  output logic                        err_spurious,
  output logic [31:0]                 stat_req,
  output logic [31:0]                 stat_resp,
  output logic [$clog2(NUM_TAGS):0]   stat_peak
);

  localparam int TAG_W = $clog2(NUM_TAGS);
  localparam int CNT_W = TAG_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_TAGS);

  // Handshake: an upstream request transfers on a cycle where up_rd_en and
  // up_rd_available are both high; responses have no back-pressure and are
  // consumed on every cycle cci_resp_valid is high.
  logic [NUM_TAGS-1:0] busy;
  logic [MDATA_W-1:0]  mdata_tbl [NUM_TAGS];
  logic [TAG_W-1:0]    free_tag;
  logic [TAG_W-1:0]    resp_tag;
  logic                accept;
  logic                resp_in_range;
  logic                resp_hit;
  logic                resp_spur;
  logic [CNT_W-1:0]    outstanding_n;

  // Lowest-index free tag: scan downwards so the last match wins.
  always_comb begin
    free_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy[i]) free_tag = TAG_W'(i);
    end
  end

  assign up_rd_available = (outstanding < FULL) && !cci_almfull;
  assign accept          = up_rd_en && up_rd_available;
  assign resp_tag        = cci_resp_mdata[TAG_W-1:0];
  assign resp_in_range   = {1'b0, cci_resp_mdata} < (MDATA_W + 1)'(NUM_TAGS);
  assign resp_hit        = cci_resp_valid && resp_in_range && busy[resp_tag];
  assign resp_spur       = cci_resp_valid && !resp_hit;
  assign idle            = (outstanding == '0);

  always_comb begin
    outstanding_n = outstanding;
    if (accept && !resp_hit)      outstanding_n = outstanding + CNT_W'(1);
    else if (!accept && resp_hit) outstanding_n = outstanding - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy          <= '0;
      outstanding   <= '0;
      cci_rd_en     <= 1'b0;
      cci_rd_addr   <= '0;
      cci_rd_mdata  <= '0;
      up_resp_valid <= 1'b0;
      up_resp_mdata <= '0;
      up_resp_data  <= '0;
      err_spurious  <= 1'b0;
    end else begin
      cci_rd_en     <= accept;
      up_resp_valid <= resp_hit;
      outstanding   <= outstanding_n;
      if (accept) begin
        busy[free_tag] <= 1'b1;
        cci_rd_addr    <= up_rd_addr;
        cci_rd_mdata   <= MDATA_W'(free_tag);
      end
      // The allocated tag is never busy, so these two bit updates never collide.
      if (resp_hit) begin
        busy[resp_tag] <= 1'b0;
        up_resp_mdata  <= mdata_tbl[resp_tag];
        up_resp_data   <= cci_resp_data;
      end
      if (resp_spur) err_spurious <= 1'b1;
    end
  end

  // Table contents are only meaningful while the matching busy bit is set.
  always_ff @(posedge clk) begin
    if (accept) mdata_tbl[free_tag] <= up_rd_mdata;
  end

`ifdef RD_TAG_TRACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_req  <= '0;
      stat_resp <= '0;
      stat_peak <= '0;
    end else begin
      if (accept)                    stat_req  <= stat_req + 32'd1;
      if (resp_hit)                  stat_resp <= stat_resp + 32'd1;
      if (outstanding_n > stat_peak) stat_peak <= outstanding_n;
    end
  end
`else
  assign stat_req  = '0;
  assign stat_resp = '0;
  assign stat_peak = '0;
`endif

endmodule

// File: tb/tb_rd_tag_tracker.sv
// Self-checking bench for rd_tag_tracker: reset checks, vector table, directed corners, random vs model.
module tb_rd_tag_tracker;

  localparam int N  = 32;
  localparam int AW = 48;
  localparam int MW = 16;
  localparam int DW = 512;
  localparam int CW = 6;

  logic          clk;
  logic          rst;
  logic          up_rd_en;
  logic          up_rd_available;
  logic [AW-1:0] up_rd_addr;
  logic [MW-1:0] up_rd_mdata;
  logic          cci_rd_en;
  logic [AW-1:0] cci_rd_addr;
  logic [MW-1:0] cci_rd_mdata;
  logic          cci_almfull;
  logic          cci_resp_valid;
  logic [MW-1:0] cci_resp_mdata;
  logic [DW-1:0] cci_resp_data;
  logic          up_resp_valid;
  logic [MW-1:0] up_resp_mdata;
  logic [DW-1:0] up_resp_data;
  logic [CW-1:0] outstanding;
  logic          idle;
  logic          err_spurious;
  logic [31:0]   stat_req;
  logic [31:0]   stat_resp;
  logic [CW-1:0] stat_peak;

  rd_tag_tracker dut (
    .clk(clk), .rst(rst),
    .up_rd_en(up_rd_en), .up_rd_available(up_rd_available),
    .up_rd_addr(up_rd_addr), .up_rd_mdata(up_rd_mdata),
    .cci_rd_en(cci_rd_en), .cci_rd_addr(cci_rd_addr), .cci_rd_mdata(cci_rd_mdata),
    .cci_almfull(cci_almfull),
    .cci_resp_valid(cci_resp_valid), .cci_resp_mdata(cci_resp_mdata),
    .cci_resp_data(cci_resp_data),
    .up_resp_valid(up_resp_valid), .up_resp_mdata(up_resp_mdata),
    .up_resp_data(up_resp_data),
    .outstanding(outstanding), .idle(idle), .err_spurious(err_spurious),
    .stat_req(stat_req), .stat_resp(stat_resp), .stat_peak(stat_peak)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: set of tags in use, parked mdata, expected registered outputs
  bit            m_busy [N];
  logic [MW-1:0] m_tbl  [N];
  logic          e_cci_en;
  logic [AW-1:0] e_cci_addr;
  logic [MW-1:0] e_cci_md;
  logic          e_rv;
  logic [MW-1:0] e_rmd;
  logic [DW-1:0] e_rdata;
  logic          e_err;
  int            m_req, m_resp, m_peak;

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic [MW-1:0] md;
    logic          rv;
    logic [MW-1:0] rtag;
    logic          x_en;
    logic [MW-1:0] x_tag;
    logic          x_rv;
    logic [MW-1:0] x_rmd;
    int            x_out;
  } vec_t;
  vec_t vt [11];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  function automatic int m_lowest_free();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
    e_cci_en = 0; e_cci_addr = '0; e_cci_md = '0;
    e_rv = 0; e_rmd = '0; e_rdata = '0; e_err = 0;
    m_req = 0; m_resp = 0; m_peak = 0;
  endtask

  // driver: inputs already set by caller; predicts the edge, clocks it, checks outputs
  task automatic cycle();
    int  cnt, ft, rt;
    bit  acc, hit;
    #1;
    cnt = m_count();
    chk("avail", up_rd_available, (cnt < N) && !cci_almfull);
    if (rst) begin
      reset_model();
    end else begin
      acc = up_rd_en && (cnt < N) && !cci_almfull;
      ft  = m_lowest_free();
      rt  = int'(cci_resp_mdata);
      hit = cci_resp_valid && (rt < N) && m_busy[rt];
      e_rv = hit;
      if (hit) begin
        e_rmd     = m_tbl[rt];
        e_rdata   = cci_resp_data;
        m_busy[rt] = 1'b0;
        m_resp++;
      end else if (cci_resp_valid) begin
        e_err = 1'b1;
      end
      e_cci_en = acc;
      if (acc) begin
        e_cci_addr = up_rd_addr;
        e_cci_md   = MW'(ft);
        m_busy[ft] = 1'b1;
        m_tbl[ft]  = up_rd_mdata;
        m_req++;
      end
      if (m_count() > m_peak) m_peak = m_count();
    end
    @(posedge clk);
    #1;
    chk("cci_rd_en", cci_rd_en, e_cci_en);
    chk("cci_rd_addr", cci_rd_addr, e_cci_addr);
    chk("cci_rd_mdata", cci_rd_mdata, e_cci_md);
    chk("up_resp_valid", up_resp_valid, e_rv);
    chk("up_resp_mdata", up_resp_mdata, e_rmd);
    chk_data("up_resp_data", up_resp_data, e_rdata);
    chk("outstanding", outstanding, m_count());
    chk("idle", idle, m_count() == 0);
    chk("err_spurious", err_spurious, e_err);
  endtask

  task automatic idle_in();
    up_rd_en = 0; cci_resp_valid = 0; cci_almfull = 0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  task automatic req(input logic [MW-1:0] md);
    up_rd_en = 1; up_rd_mdata = md; up_rd_addr = AW'(md) << 6;
  endtask

  task automatic resp(input logic [MW-1:0] tag);
    cci_resp_valid = 1; cci_resp_mdata = tag;
  endtask

  initial begin
    logic [DW-1:0] pat;
    int            q[$];
    pat = {16{32'h5555_5555}};
    rst = 1; up_rd_en = 0; up_rd_addr = '0; up_rd_mdata = '0; cci_almfull = 0;
    cci_resp_valid = 0; cci_resp_mdata = '0; cci_resp_data = pat;

    vt[0]  = '{1'b1, 48'h1000, 16'h00AB, 1'b0, 16'd0, 1'b1, 16'd0, 1'b0, 16'd0,  1};
    vt[1]  = '{1'b0, 48'h0,    16'h0,    1'b1, 16'd0, 1'b0, 16'd0, 1'b1, 16'hAB, 0};
    vt[2]  = '{1'b1, 48'h2000, 16'd10,   1'b0, 16'd0, 1'b1, 16'd0, 1'b0, 16'd0,  1};
    vt[3]  = '{1'b1, 48'h2040, 16'd11,   1'b0, 16'd0, 1'b1, 16'd1, 1'b0, 16'd0,  2};
    vt[4]  = '{1'b1, 48'h2080, 16'd12,   1'b0, 16'd0, 1'b1, 16'd2, 1'b0, 16'd0,  3};
    vt[5]  = '{1'b1, 48'h20C0, 16'd13,   1'b0, 16'd0, 1'b1, 16'd3, 1'b0, 16'd0,  4};
    vt[6]  = '{1'b0, 48'h0,    16'd0,    1'b1, 16'd3, 1'b0, 16'd3, 1'b1, 16'd13, 3};
    vt[7]  = '{1'b0, 48'h0,    16'd0,    1'b1, 16'd1, 1'b0, 16'd3, 1'b1, 16'd11, 2};
    vt[8]  = '{1'b0, 48'h0,    16'd0,    1'b1, 16'd0, 1'b0, 16'd3, 1'b1, 16'd10, 1};
    vt[9]  = '{1'b1, 48'h3000, 16'd20,   1'b1, 16'd2, 1'b1, 16'd0, 1'b1, 16'd12, 1};
    vt[10] = '{1'b0, 48'h0,    16'd0,    1'b1, 16'd0, 1'b0, 16'd0, 1'b1, 16'd20, 0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cci_rd_en", cci_rd_en, 0);
    chk("rst_cci_rd_addr", cci_rd_addr, 0);
    chk("rst_cci_rd_mdata", cci_rd_mdata, 0);
    chk("rst_up_resp_valid", up_resp_valid, 0);
    chk("rst_up_resp_mdata", up_resp_mdata, 0);
    chk_data("rst_up_resp_data", up_resp_data, '0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", err_spurious, 0);
    chk("rst_avail", up_rd_available, 1);
    cci_almfull = 1;
    #1 chk("rst_avail_almfull", up_rd_available, 0);
    reset_model();
    rst = 0;
    idle_in();

    // vector table: single read, out-of-order return, accept+free
    for (int i = 0; i < 11; i++) begin
      up_rd_en = vt[i].en; up_rd_addr = vt[i].addr; up_rd_mdata = vt[i].md;
      cci_resp_valid = vt[i].rv; cci_resp_mdata = vt[i].rtag;
      cycle();
      chk("vec_cci_en", cci_rd_en, vt[i].x_en);
      if (vt[i].x_en) chk("vec_cci_addr", cci_rd_addr, vt[i].addr);
      chk("vec_cci_tag", cci_rd_mdata, vt[i].x_tag);
      chk("vec_resp_valid", up_resp_valid, vt[i].x_rv);
      if (vt[i].x_rv) begin
        chk("vec_resp_mdata", up_resp_mdata, vt[i].x_rmd);
        chk_data("vec_resp_data", up_resp_data, pat);
      end
      chk("vec_outstanding", outstanding, vt[i].x_out);
      chk("vec_idle", idle, vt[i].x_out == 0);
    end
    idle_in();

    // fill all tags, free 7, reallocate 7
    do_reset();
    for (int i = 0; i < N; i++) begin
      req(MW'(100 + i));
      cycle();
      chk("fill_tag", cci_rd_mdata, i);
    end
    chk("fill_out", outstanding, N);
    chk("fill_avail", up_rd_available, 0);
    cycle();
    chk("fill_no_issue", cci_rd_en, 0);
    idle_in();
    resp(7);
    cycle();
    chk("free7_mdata", up_resp_mdata, 107);
    idle_in();
    #1 chk("free7_avail", up_rd_available, 1);
    req(16'h77);
    cycle();
    chk("realloc_tag", cci_rd_mdata, 7);
    chk("realloc_en", cci_rd_en, 1);
    idle_in();

    // accept and free together at outstanding=5
    do_reset();
    for (int i = 0; i < 5; i++) begin req(MW'(i)); cycle(); end
    req(16'h50); resp(2);
    cycle();
    chk("simul_out", outstanding, 5);
    chk("simul_tag", cci_rd_mdata, 5);
    chk("simul_resp", up_resp_mdata, 2);
    idle_in();
    req(16'h51);
    cycle();
    chk("simul_reuse_tag", cci_rd_mdata, 2);
    chk("simul_out2", outstanding, 6);
    idle_in();

    // spurious response on free tag 9, held until reset
    resp(9);
    cycle();
    chk("spur_valid", up_resp_valid, 0);
    chk("spur_err", err_spurious, 1);
    idle_in();
    repeat (3) cycle();
    chk("spur_held", err_spurious, 1);
    do_reset();
    chk("spur_cleared", err_spurious, 0);
    resp(16'd40);
    cycle();
    chk("oor_err", err_spurious, 1);
    chk("oor_valid", up_resp_valid, 0);
    idle_in();

    // almfull then reset with 4 outstanding
    do_reset();
    for (int i = 0; i < 4; i++) begin req(MW'(i)); cycle(); end
    req(16'h99); cci_almfull = 1;
    #1 chk("almfull_avail", up_rd_available, 0);
    cycle();
    chk("almfull_no_issue", cci_rd_en, 0);
    cycle();
    chk("almfull_no_issue2", cci_rd_en, 0);
    idle_in();
    rst = 1;
    cycle();
    rst = 0;
    chk("mid_rst_out", outstanding, 0);
    chk("mid_rst_idle", idle, 1);
    resp(2);
    cycle();
    chk("stale_err", err_spurious, 1);
    chk("stale_valid", up_resp_valid, 0);
    idle_in();

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 599) == 0);
      up_rd_en = ($urandom_range(0, 99) < 60);
      cci_almfull = ($urandom_range(0, 99) < 10);
      up_rd_addr = {$urandom, $urandom};
      up_rd_mdata = MW'($urandom);
      for (int k = 0; k < DW / 32; k++) cci_resp_data[k*32 +: 32] = $urandom;
      cci_resp_valid = ($urandom_range(0, 99) < 55);
      q.delete();
      for (int t = 0; t < N; t++) if (m_busy[t]) q.push_back(t);
      if (q.size() > 0 && $urandom_range(0, 99) < 92)
        cci_resp_mdata = MW'(q[$urandom_range(0, q.size() - 1)]);
      else
        cci_resp_mdata = MW'($urandom_range(0, 63));
      cycle();
    end
    rst = 0;
    idle_in();
    cycle();

`ifdef RD_TAG_TRACKER_STATS_EN
    chk("stat_req", stat_req, m_req);
    chk("stat_resp", stat_resp, m_resp);
    chk("stat_peak", stat_peak, m_peak);
`else
    chk("stat_req_tied", stat_req, 0);
    chk("stat_resp_tied", stat_resp, 0);
    chk("stat_peak_tied", stat_peak, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
